// File: rtl/panda_lsu_bus.sv
// panda_lsu_bus: MEM-stage load/store unit with req/gnt/rvalid data bus, misaligned split and timeout
module panda_lsu_bus #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter bit          MISALIGNED_EN  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_store_i,
  input  logic [1:0]            req_width_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic                  data_err_i,
  input  logic [31:0]           data_rdata_i
);
  typedef enum logic [2:0] {IDLE, ADDR1, WAIT1, ADDR2, WAIT2, ERR} state_t;
  state_t state, state_d;
  logic store_q, uns_q, mis_q, done, err, hi_ph;
  logic [1:0] width_q, off_q, off;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [63:0] wdata_q;
  logic [7:0] be_q;
  logic [31:0] lo_q, cnt_q, lo_v, hi_v, sh, ext;
  logic [3:0] mask_in;
  logic mis_in, wait_st;
  assign off     = req_addr_i[1:0];
  assign mis_in  = (req_width_i[1] & off != 2'd0) | (req_width_i == 2'b01 & off == 2'd3);
  assign mask_in = req_width_i[1] ? 4'hf : req_width_i[0] ? 4'h3 : 4'h1;
  assign wait_st = state == WAIT1 || state == WAIT2;
  assign req_ready_o  = state == IDLE;
  assign busy_o       = state != IDLE;
  assign data_req_o   = state == ADDR1 || state == ADDR2;
  assign hi_ph        = state == ADDR2;
  assign data_addr_o  = !data_req_o ? '0 : hi_ph ? base_q + ADDR_WIDTH'(4) : base_q;
  assign data_we_o    = data_req_o & store_q;
  assign data_be_o    = !data_req_o ? 4'h0 : hi_ph ? be_q[7:4] : be_q[3:0];
  assign data_wdata_o = !data_req_o ? 32'h0 : hi_ph ? wdata_q[63:32] : wdata_q[31:0];
  // the final response word is still on the bus when the last rvalid arrives
  assign lo_v = state == WAIT1 ? data_rdata_i : lo_q;
  assign hi_v = state == WAIT2 ? data_rdata_i : 32'h0;
  assign sh   = 32'({hi_v, lo_v} >> {off_q, 3'b000});
  assign ext  = width_q[1] ? sh : width_q[0] ? {{16{~uns_q & sh[15]}}, sh[15:0]}
                                             : {{24{~uns_q & sh[7]}}, sh[7:0]};
  always_comb begin
    state_d = state;
    done    = 1'b0;
    err     = 1'b0;
    case (state)
      IDLE:         if (req_valid_i) state_d = (mis_in && !MISALIGNED_EN) ? ERR : ADDR1;
      ADDR1:        if (data_gnt_i) state_d = WAIT1;
      ADDR2:        if (data_gnt_i) state_d = WAIT2;
      WAIT1, WAIT2: begin
        if (data_rvalid_i) begin
          err  = data_err_i;
          done = data_err_i || state == WAIT2 || !mis_q;
          if (!done) state_d = ADDR2;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          done = 1'b1;
          err  = 1'b1;
        end
      end
      ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (done) state_d = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= 32'h0;
      cnt_q       <= 32'h0;
      store_q     <= 1'b0;
      uns_q       <= 1'b0;
      mis_q       <= 1'b0;
      width_q     <= 2'b00;
      off_q       <= 2'b00;
      base_q      <= '0;
      wdata_q     <= 64'h0;
      be_q        <= 8'h0;
      lo_q        <= 32'h0;
    end else begin
      state       <= state_d;
      rsp_valid_o <= done;
      cnt_q       <= wait_st ? cnt_q + 32'd1 : 32'h0;
      if (done) begin
        rsp_err_o   <= err;
        rsp_rdata_o <= (err || store_q) ? 32'h0 : ext;
      end
      if (state == IDLE && req_valid_i) begin
        store_q <= req_store_i;
        uns_q   <= req_unsigned_i;
        mis_q   <= mis_in;
        width_q <= req_width_i;
        off_q   <= off;
        base_q  <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
        wdata_q <= {32'h0, req_wdata_i} << {off, 3'b000};
        be_q    <= {4'h0, mask_in} << off;
      end
      if (state == WAIT1 && data_rvalid_i) lo_q <= data_rdata_i;
    end
  end
endmodule

// File: tb/tb_panda_lsu_bus.sv
// tb_panda_lsu_bus: directed self-checking bench for panda_lsu_bus
module tb_panda_lsu_bus;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, valid_na = 1'b0, store = 1'b0, uns = 1'b0;
  logic [1:0] width = 2'b10;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic gnt = 1'b0, rvalid = 1'b0, berr = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic ready, rsp_valid, rsp_err, busy, dreq, we;
  logic [31:0] rsp_rdata, daddr, dwdata;
  logic [3:0] be;
  logic ready_na, rsp_valid_na, rsp_err_na, busy_na, dreq_na, we_na;
  logic [31:0] rsp_rdata_na, daddr_na, dwdata_na;
  logic [3:0] be_na;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  panda_lsu_bus #(.ADDR_WIDTH(32), .MISALIGNED_EN(1'b1), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready),
    .req_store_i(store), .req_width_i(width), .req_unsigned_i(uns), .req_addr_i(addr),
    .req_wdata_i(wdata), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .busy_o(busy), .data_req_o(dreq), .data_gnt_i(gnt), .data_addr_o(daddr), .data_we_o(we),
    .data_be_o(be), .data_wdata_o(dwdata), .data_rvalid_i(rvalid), .data_err_i(berr),
    .data_rdata_i(rdata));

  panda_lsu_bus #(.ADDR_WIDTH(32), .MISALIGNED_EN(1'b0), .TIMEOUT_CYCLES(0)) dut_na (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid_na), .req_ready_o(ready_na),
    .req_store_i(store), .req_width_i(width), .req_unsigned_i(uns), .req_addr_i(addr),
    .req_wdata_i(wdata), .rsp_valid_o(rsp_valid_na), .rsp_rdata_o(rsp_rdata_na),
    .rsp_err_o(rsp_err_na), .busy_o(busy_na), .data_req_o(dreq_na), .data_gnt_i(gnt),
    .data_addr_o(daddr_na), .data_we_o(we_na), .data_be_o(be_na), .data_wdata_o(dwdata_na),
    .data_rvalid_i(rvalid), .data_err_i(berr), .data_rdata_i(rdata));

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // present a request for one cycle; returns at the negedge of the cycle after acceptance
  task automatic issue(input logic st, input logic [1:0] w, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    chk("ready_before_issue", ready, 1'b1);
    req_valid = 1'b1; store = st; width = w; uns = u; addr = a; wdata = d;
    tick;
    req_valid = 1'b0;
  endtask

  // check the pending bus request, grant it, then return a response the next cycle
  task automatic beat(input string tag, input logic [31:0] ea, input logic [3:0] ebe,
                      input logic ewe, input logic [31:0] ewd, input logic [31:0] rd, input logic e);
    chk({tag, "_req"}, dreq, 1'b1);
    chk({tag, "_addr"}, daddr, ea);
    chk({tag, "_be"}, be, ebe);
    chk({tag, "_we"}, we, ewe);
    chk({tag, "_wdata"}, dwdata, ewd);
    gnt = 1'b1;
    tick;
    gnt = 1'b0;
    chk({tag, "_req_low_in_wait"}, dreq, 1'b0);
    rvalid = 1'b1; rdata = rd; berr = e;
    tick;
    rvalid = 1'b0; berr = 1'b0; rdata = 32'h0;
  endtask

  task automatic rsp(input string tag, input logic v, input logic e, input logic [31:0] d);
    chk({tag, "_valid"}, rsp_valid, v);
    chk({tag, "_err"}, rsp_err, e);
    chk({tag, "_rdata"}, rsp_rdata, d);
  endtask

  initial begin
    tick; tick;
    rst = 1'b0;
    tick;
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_data_req", dreq, 1'b0);
    chk("rst_be", be, 4'h0);
    chk("rst_addr", daddr, 32'h0);

    // aligned LW, minimum latency
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    beat("lw", 32'h100, 4'hf, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    rsp("lw", 1'b1, 1'b0, 32'hDEADBEEF);
    chk("lw_ready_with_rsp", ready, 1'b1);
    tick;
    chk("lw_rsp_one_cycle", rsp_valid, 1'b0);

    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    beat("lb", 32'h100, 4'h8, 1'b0, 32'h0, 32'h80112233, 1'b0);
    rsp("lb", 1'b1, 1'b0, 32'hFFFFFF80);
    tick;
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    beat("lbu", 32'h100, 4'h8, 1'b0, 32'h0, 32'h80112233, 1'b0);
    rsp("lbu", 1'b1, 1'b0, 32'h00000080);
    tick;
    issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
    beat("lh", 32'h100, 4'hc, 1'b0, 32'h0, 32'h9ABC1234, 1'b0);
    rsp("lh", 1'b1, 1'b0, 32'hFFFF9ABC);
    tick;

    // misaligned SW split
    issue(1'b1, 2'b10, 1'b0, 32'h202, 32'hAABBCCDD);
    beat("sw1", 32'h200, 4'hc, 1'b1, 32'hCCDD0000, 32'h0, 1'b0);
    chk("sw_no_rsp_mid", rsp_valid, 1'b0);
    beat("sw2", 32'h204, 4'h3, 1'b1, 32'h0000AABB, 32'h0, 1'b0);
    rsp("sw", 1'b1, 1'b0, 32'h0);
    tick;
    chk("sw_single_rsp", rsp_valid, 1'b0);

    // misaligned LW split
    issue(1'b0, 2'b10, 1'b0, 32'h0FF, 32'h0);
    beat("lwm1", 32'h0FC, 4'h8, 1'b0, 32'h0, 32'h44332211, 1'b0);
    beat("lwm2", 32'h100, 4'h7, 1'b0, 32'h0, 32'h88776655, 1'b0);
    rsp("lwm", 1'b1, 1'b0, 32'h77665544);
    tick;

    // address wrap on the second half
    issue(1'b0, 2'b01, 1'b1, 32'hFFFFFFFF, 32'h0);
    beat("wrap1", 32'hFFFFFFFC, 4'h8, 1'b0, 32'h0, 32'hAB000000, 1'b0);
    beat("wrap2", 32'h00000000, 4'h1, 1'b0, 32'h0, 32'h000000CD, 1'b0);
    rsp("wrap", 1'b1, 1'b0, 32'h0000CDAB);
    tick;

    // misaligned rejected when splitting is disabled
    valid_na = 1'b1; width = 2'b10; addr = 32'h0FF; store = 1'b0;
    tick;
    valid_na = 1'b0;
    chk("na_no_req", dreq_na, 1'b0);
    chk("na_no_rsp_early", rsp_valid_na, 1'b0);
    tick;
    chk("na_rsp_valid", rsp_valid_na, 1'b1);
    chk("na_rsp_err", rsp_err_na, 1'b1);
    chk("na_rsp_rdata", rsp_rdata_na, 32'h0);
    chk("na_ready", ready_na, 1'b1);
    tick;

    // grant withheld 5 cycles
    issue(1'b1, 2'b10, 1'b0, 32'h300, 32'h01020304);
    for (int i = 0; i < 5; i++) begin
      chk("bp_req", dreq, 1'b1);
      chk("bp_addr", daddr, 32'h300);
      chk("bp_be", be, 4'hf);
      chk("bp_we", we, 1'b1);
      chk("bp_ready_low", ready, 1'b0);
      tick;
    end
    beat("bp", 32'h300, 4'hf, 1'b1, 32'h01020304, 32'h0, 1'b0);
    rsp("bp", 1'b1, 1'b0, 32'h0);
    tick;

    // bus error on first half of a split load
    issue(1'b0, 2'b10, 1'b0, 32'h0FF, 32'h0);
    beat("be1", 32'h0FC, 4'h8, 1'b0, 32'h0, 32'h11111111, 1'b1);
    rsp("berr", 1'b1, 1'b1, 32'h0);
    chk("berr_no_req2", dreq, 1'b0);
    tick;
    chk("berr_no_req2_later", dreq, 1'b0);
    chk("berr_idle", busy, 1'b0);

    // response timeout after 4 wait cycles
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    chk("to_req", dreq, 1'b1);
    gnt = 1'b1;
    tick;
    gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_waiting", rsp_valid, 1'b0);
      chk("to_busy", busy, 1'b1);
      tick;
    end
    rsp("to", 1'b1, 1'b1, 32'h0);
    chk("to_idle", busy, 1'b0);
    tick;

    // reset while waiting for a response
    issue(1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
    gnt = 1'b1;
    tick;
    gnt = 1'b0;
    chk("rw_in_wait", busy, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rw_idle", busy, 1'b0);
    chk("rw_no_rsp", rsp_valid, 1'b0);
    chk("rw_ready", ready, 1'b1);
    rvalid = 1'b1; rdata = 32'h55555555;
    tick;
    rvalid = 1'b0;
    chk("rw_late_rvalid_ignored", rsp_valid, 1'b0);
    chk("rw_still_idle", busy, 1'b0);
    tick;
    chk("rw_no_rsp_after", rsp_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/panda_lsu_bus.md
Name: panda_lsu_bus

Overview:
- Multi-cycle load/store unit for the MEM stage. It replaces the single-cycle combinational memory path with a request/grant/response data-bus handshake.
- Splits misaligned accesses into two aligned word transactions and recombines load data.
- Reports bus errors and response timeouts.
- Back-pressures the pipeline through req_ready_o; at most one bus transaction is outstanding.

Parameters:
- ADDR_WIDTH, 32, width of req_addr_i and data_addr_o.
- MISALIGNED_EN, 1, 1: split misaligned accesses; 0: reject them with an error and no bus activity.
- TIMEOUT_CYCLES, 0, max cycles waiting for data_rvalid_i after a grant; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  MEM-stage access request
- req_ready_o  out  1  unit idle and able to accept a request
- req_store_i  in  1  1 store, 0 load
- req_width_i  in  2  00 byte, 01 half, 10 word (11 treated as word)
- req_unsigned_i  in  1  zero-extend load result
- req_addr_i  in  ADDR_WIDTH  byte address
- req_wdata_i  in  32  store data, LSB-aligned
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_rdata_o  out  32  extended load data (0 for stores and errors)
- rsp_err_o  out  1  error qualifier, valid with rsp_valid_o
- busy_o  out  1  state != IDLE
- data_req_o  out  1  bus request
- data_gnt_i  in  1  bus grant
- data_addr_o  out  ADDR_WIDTH  word-aligned bus address
- data_we_o  out  1  bus write enable
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  lane-shifted write data
- data_rvalid_i  in  1  bus response valid
- data_err_i  in  1  bus error, qualified by data_rvalid_i
- data_rdata_i  in  32  bus read data

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset state:
  - State goes to IDLE.
  - rsp_valid_o, rsp_err_o, rsp_rdata_o, data_req_o, data_we_o, data_be_o, data_wdata_o, data_addr_o and the timeout counter go to 0.
  - req_ready_o=1 and busy_o=0 in the first cycle after reset.
  - Reset mid-transaction abandons the transaction; no response is produced.
- States: IDLE, ADDR1, WAIT1, ADDR2, WAIT2, ERR.
- IDLE:
  - req_ready_o=1 (combinational from state).
  - On req_valid_i & req_ready_o, latch the request. Compute off=addr[1:0], base=addr & ~3, and mis = (word & off!=0) | (half & off==3).
  - If mis and MISALIGNED_EN=0, go to ERR. Otherwise go to ADDR1.
- ADDR1:
  - Drive data_req_o=1, data_addr_o=base, data_we_o=store, data_be_o=(mask<<off)[3:0], data_wdata_o=wdata<<(8*off).
  - Mask is 0001, 0011 or 1111 for byte, half and word.
  - All bus outputs stay stable until data_gnt_i. On grant, go to WAIT1.
- WAIT1:
  - data_req_o=0. Wait for data_rvalid_i and capture data_rdata_i into lo.
  - If data_err_i=1, complete with an error.
  - Else if mis, go to ADDR2. Else complete.
- ADDR2:
  - data_addr_o=base+4, data_be_o=(mask<<off)[7:4], data_wdata_o=(wdata<<(8*off))[63:32].
  - On grant, go to WAIT2.
- WAIT2: on data_rvalid_i, capture hi and complete; data_err_i=1 completes with an error.
- ERR: one cycle, then complete with an error.
- Completion:
  - Next rising edge: rsp_valid_o=1 for exactly one cycle, and the state returns to IDLE.
  - req_ready_o rises in the same cycle as rsp_valid_o. A new request may be accepted in that cycle.
- Load result:
  - Shift {hi,lo} (hi=0 when not split) right by 8*off and take the low byte, half or word.
  - Sign-extend unless req_unsigned_i=1.
  - rsp_rdata_o=0 when rsp_err_o=1 or the access is a store.
- Stores also wait for data_rvalid_i before completing.
- data_rvalid_i outside WAIT1/WAIT2 is ignored.
- A grant in the same cycle the request first appears is legal. Minimum latency is acceptance at N, data_req_o at N+1, gnt at N+1, rvalid at N+2, rsp_valid_o at N+3.
- Timeout:
  - If TIMEOUT_CYCLES>0, a counter clears on entry to WAIT1/WAIT2 and increments each cycle without rvalid.
  - When it reaches TIMEOUT_CYCLES, complete with an error and drop the remaining split half.
  - Grant waits are never timed out.
- Address arithmetic for base+4 wraps modulo 2^ADDR_WIDTH.

Test Plan:
- Aligned LW at 0x100, gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF -> rsp_valid_o 3 cycles after acceptance, rsp_rdata_o=0xDEADBEEF, err=0.
- LB at 0x103, rdata 0x80112233 -> be=1000, rsp_rdata_o=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SW of 0xAABBCCDD at 0x202, MISALIGNED_EN=1 -> two bus transactions:
  - First: addr 0x200, be=1100, wdata 0xCCDD0000.
  - Second: addr 0x204, be=0011, wdata 0x0000AABB.
  - Single rsp_valid_o after the second rvalid.
- LW at 0x0FF, MISALIGNED_EN=1, rdata 0x44332211 then 0x88776655 -> rsp_rdata_o=0x77665544. Same access with MISALIGNED_EN=0 -> no data_req_o, rsp_valid_o+rsp_err_o 2 cycles after acceptance.
- Back-pressure and bus error:
  - gnt withheld 5 cycles -> data_addr_o/be/we stable throughout.
  - First-half rvalid with data_err_i=1 on a split load -> no second request, rsp_err_o=1, rdata=0.
- TIMEOUT_CYCLES=4, rvalid never arrives -> rsp_err_o=1 after 4 WAIT cycles, unit returns to IDLE.
- rst_i asserted in WAIT1 -> next cycle IDLE, no rsp_valid_o, and a late rvalid is ignored.
